m68k_region_decoder: RTL and testbench
======================================

// Module: m68k_region_decoder
// PURPOSE
//  Parametrised, registered 68000 address decoder: N address regions from a packed table, one-hot
//  selects latched per bus cycle, per-region wait states, DTACK generation with external-ready stretch.
//  Sits between the 68000 core and all main-CPU peripherals (ROM, RAM, palette, tilemap, CRTC, sound latch).
//  Z80 I/O decode is out of scope.
// PARAMETERS
//  N_REGIONS   8          number of decoded regions (1..32)
//  REG_START   {N x 24b}  packed region start byte addresses, region 0 in LSBs
//  REG_END     {N x 24b}  packed region end byte addresses (inclusive)
//  REG_WAIT    {N x 4b}   wait states per region, 0..15 clocks
//  REG_EXTRDY  {N x 1b}   1 = region also waits for ext_ready (SDRAM-backed)
//  BERR_CYCLES 255        timeout in clocks before bus error (BERR_TIMEOUT_EN only)
// PORTS
//  clk_sys    in   1          system clock, all logic on rising edge
//  reset_n    in   1          asynchronous active-low reset
//  cpu_a      in   24         68000 byte address (A0 from UDS/LDS)
//  cpu_as_n   in   1          address strobe, active low
//  cpu_ds_n   in   2          {UDS_n, LDS_n}
//  ext_ready  in   1          external ready for REG_EXTRDY regions
//  cs         out  N_REGIONS  registered one-hot region selects
//  hit_idx    out  5          index of selected region (valid while any cs set)
//  cpu_dtack_n out 1          data transfer acknowledge, active low
//  cpu_berr_n out  1          bus error, active low (held 1 without BERR_TIMEOUT_EN)
//  busy       out  1          high from DECODE through end of cycle
// BEHAVIOUR
//  Reset: cs=0, hit_idx=0, cpu_dtack_n=1, cpu_berr_n=1, busy=0, state IDLE, wait counter 0.
//  Region match: start <= cpu_a <= end; lowest index wins on overlap (priority, not error).
//  FSM (one transition per clk_sys):
//   IDLE   : AS_n=0 and DS_n!=2'b11 -> DECODE.
//   DECODE : latch cpu_a match; hit -> cs[i]=1, hit_idx=i, cnt=REG_WAIT[i] -> WAIT; no hit -> UNMAP.
//   WAIT   : cnt>0 -> cnt--. cnt==0 and (!REG_EXTRDY[i] or ext_ready) -> ACK.
//   ACK    : cpu_dtack_n=0, held until AS_n=1 -> IDLE (cs, hit_idx, dtack cleared same edge).
//   UNMAP  : cs=0; dtack never asserted; stays until AS_n=1 (or BERR, see CONFIGURATION).
//  Latency: WAIT=0, non-EXTRDY region -> DTACK low on 3rd rising edge after AS_n/DS_n sampled low.
//  cs is stable for the whole bus cycle; a mid-cycle change of cpu_a does not re-decode.
//  AS_n rising in any state (abort, incl. WAIT/UNMAP) -> IDLE next edge, all outputs to reset values.
//  AS_n high and low within the same cycle: not re-entered until IDLE has been visited >=1 clock.
//  ext_ready sampled only in WAIT with cnt==0; earlier pulses are ignored, not remembered.
//  reset_n low mid-cycle: outputs to reset values immediately (async); DTACK never glitches low.
//  Counter is 4 bits; the REG_WAIT=15 path takes exactly 15 extra clocks, no wrap.
// CONFIGURATION
//  BERR_TIMEOUT_EN defined: 8-bit timeout counter runs in UNMAP, and in WAIT while EXTRDY is pending;
//   at BERR_CYCLES -> cpu_berr_n=0 until AS_n=1, then IDLE. DTACK is never asserted with BERR.
//  BERR_TIMEOUT_EN undefined: no timeout counter; cpu_berr_n tied 1; UNMAP waits for AS_n high
//   (CPU hangs, matching original board behaviour).
// STRUCTURE
//  Package m68k_decode_pkg: state enum (IDLE, DECODE, WAIT, ACK, UNMAP), field widths
//   ADDR_W=24, WAIT_W=4, IDX_W=5, helper function region_field(table, idx, width).
//  Sub-module region_match: combinational N-way range compare plus priority encoder
//   -> {hit, idx}; the FSM and counters stay in the top module.
// TESTING
//  1. Region 0 0x000000-0x07FFFF wait 0; read 0x001234 -> cs[0] on DECODE edge; DTACK low 3rd edge; AS_n high -> all clear.
//  2. Region 3 wait 5; access 0x140002 -> DTACK low exactly 5 clocks later than test 1; hit_idx=3 throughout.
//  3. EXTRDY region wait 2, ext_ready pulsed at cnt=1 then raised 10 clocks later -> DTACK follows the later rise only.
//  4. Overlapping regions 1 and 2 both cover 0x100010 -> only cs[1]; one-hot checked every cycle.
//  5. Unmapped 0x300000: BERR_TIMEOUT_EN, BERR_CYCLES=16 -> berr_n low 16 clocks after UNMAP; without the macro berr_n stays 1 and DTACK stays 1.
//  6. AS_n released in WAIT, then reset_n asserted mid-ACK -> outputs reset immediately; next access decodes normally.

Source files
------------

// File: rtl/m68k_region_decoder_pkg.sv
// m68k_decode_pkg: bus-cycle state type, field widths and a packed-table field extractor for the 68000 decoder
package m68k_decode_pkg;
    localparam int ADDR_W = 24;
    localparam int WAIT_W = 4;
    localparam int IDX_W = 5;
    localparam int TBL_W = 32 * ADDR_W;

    typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, UNMAP} state_t;

    function automatic logic [31:0] region_field(input logic [TBL_W-1:0] tbl, input int idx, input int width);
        return 32'(tbl >> (idx * width)) & ((32'd1 << width) - 32'd1);
    endfunction
endpackage

// File: rtl/m68k_region_decoder_region_match.sv
// region_match: N-way inclusive address range compare with lowest-index priority
module region_match
    import m68k_decode_pkg::*;
#(
    parameter int N_REGIONS = 8,
    parameter logic [N_REGIONS*ADDR_W-1:0] REG_START = '0,
    parameter logic [N_REGIONS*ADDR_W-1:0] REG_END = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);
    logic [N_REGIONS-1:0] in_range;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_rng
        assign in_range[g] = addr >= ADDR_W'(region_field(TBL_W'(REG_START), g, ADDR_W)) &&
                             addr <= ADDR_W'(region_field(TBL_W'(REG_END), g, ADDR_W));
    end

    assign hit = |in_range;

    // descending scan leaves the lowest matching index standing
    always_comb begin
        idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--)
            if (in_range[i]) idx = IDX_W'(i);
    end
endmodule

// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder: registered 68000 region decode, wait states and DTACK; define BERR_TIMEOUT_EN for the bus-error timeout
module m68k_region_decoder
    import m68k_decode_pkg::*;
#(
    parameter int N_REGIONS = 8,
    parameter logic [N_REGIONS*ADDR_W-1:0] REG_START = {24'h1A0000, 24'h190000, 24'h180000, 24'h200000,
                                                         24'h140000, 24'h100000, 24'h100000, 24'h000000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REG_END   = {24'h1AFFFF, 24'h19FFFF, 24'h18FFFF, 24'h2FFFFF,
                                                         24'h14FFFF, 24'h11FFFF, 24'h10FFFF, 24'h07FFFF},
    parameter logic [N_REGIONS*WAIT_W-1:0] REG_WAIT  = 32'h00F2_5310,
    parameter logic [N_REGIONS-1:0]        REG_EXTRDY = 8'h10,
    parameter int BERR_CYCLES = 255
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    cpu_a,
    input  logic                 cpu_as_n,
    input  logic [1:0]           cpu_ds_n,
    input  logic                 ext_ready,
    output logic [N_REGIONS-1:0] cs,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 cpu_dtack_n,
    output logic                 cpu_berr_n,
    output logic                 busy
);
    if (N_REGIONS < 1 || N_REGIONS > 32 || BERR_CYCLES < 1 || BERR_CYCLES > 255) begin : g_bad_cfg
        $error("m68k_region_decoder: parameter out of range");
    end

    state_t               state, state_d;
    logic [WAIT_W-1:0]    cnt, cnt_d;
    logic [N_REGIONS-1:0] cs_d;
    logic [IDX_W-1:0]     idx_d, match_idx;
    logic                 match_hit, dtack_d, ext_pend, ack_go;

    region_match #(.N_REGIONS(N_REGIONS), .REG_START(REG_START), .REG_END(REG_END)) u_match (
        .addr(cpu_a),
        .hit (match_hit),
        .idx (match_idx)
    );

    // ext_ready only matters once the wait count has run out; earlier pulses are not remembered
    assign ext_pend = 1'(region_field(TBL_W'(REG_EXTRDY), int'(hit_idx), 1)) && !ext_ready;
    assign ack_go   = cnt == '0 && !ext_pend && cpu_berr_n;
    assign busy     = state != IDLE;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cs_d    = cs;
        idx_d   = hit_idx;
        dtack_d = 1'b1;
        if (state != IDLE && cpu_as_n) begin
            state_d = IDLE;
            cnt_d   = '0;
            cs_d    = '0;
            idx_d   = '0;
        end else begin
            unique case (state)
                IDLE:   state_d = (!cpu_as_n && cpu_ds_n != 2'b11) ? DECODE : IDLE;
                DECODE: begin
                    state_d = match_hit ? WAIT : UNMAP;
                    cs_d    = match_hit ? N_REGIONS'(1) << match_idx : '0;
                    idx_d   = match_hit ? match_idx : '0;
                    cnt_d   = match_hit ? WAIT_W'(region_field(TBL_W'(REG_WAIT), int'(match_idx), WAIT_W)) : '0;
                end
                WAIT: begin
                    cnt_d   = cnt != '0 ? cnt - WAIT_W'(1) : cnt;
                    state_d = ack_go ? ACK : WAIT;
                    dtack_d = !ack_go;
                end
                ACK:    dtack_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cs          <= '0;
            hit_idx     <= '0;
            cpu_dtack_n <= 1'b1;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cs          <= cs_d;
            hit_idx     <= idx_d;
            cpu_dtack_n <= dtack_d;
        end
    end

`ifdef BERR_TIMEOUT_EN
    logic [7:0] tmo, tmo_d;
    logic       berr_d;

    // the timeout runs while the cycle can only end by CPU abort: unmapped, or stalled on ext_ready
    always_comb begin
        tmo_d  = '0;
        berr_d = 1'b1;
        if (!cpu_as_n && (state == UNMAP || (state == WAIT && cnt == '0 && ext_pend))) begin
            berr_d = cpu_berr_n && tmo != 8'(BERR_CYCLES - 1);
            tmo_d  = cpu_berr_n ? tmo + 8'd1 : tmo;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo        <= '0;
            cpu_berr_n <= 1'b1;
        end else begin
            tmo        <= tmo_d;
            cpu_berr_n <= berr_d;
        end
    end
`else
    assign cpu_berr_n = 1'b1;
`endif
endmodule

// File: tb/tb_m68k_region_decoder.sv
// tb_m68k_region_decoder: directed bus cycles with a scoreboard checked on each DTACK/BERR assertion
module tb_m68k_region_decoder;
    localparam logic [191:0] START  = {24'h1A0000, 24'h190000, 24'h180000, 24'h200000,
                                       24'h140000, 24'h100000, 24'h100000, 24'h000000};
    localparam logic [191:0] ENDS   = {24'h1AFFFF, 24'h19FFFF, 24'h18FFFF, 24'h2FFFFF,
                                       24'h14FFFF, 24'h11FFFF, 24'h10FFFF, 24'h07FFFF};
    localparam logic [31:0]  WAITS  = 32'h00F2_5310;
    localparam logic [7:0]   EXTRDY = 8'h10;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] cpu_a = '0;
    logic        cpu_as_n = 1'b1;
    logic [1:0]  cpu_ds_n = 2'b11;
    logic        ext_ready = 1'b0;
    logic [7:0]  cs;
    logic [4:0]  hit_idx;
    logic        cpu_dtack_n, cpu_berr_n, busy;

    m68k_region_decoder #(
        .N_REGIONS(8), .REG_START(START), .REG_END(ENDS), .REG_WAIT(WAITS),
        .REG_EXTRDY(EXTRDY), .BERR_CYCLES(16)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_as_n(cpu_as_n),
        .cpu_ds_n(cpu_ds_n), .ext_ready(ext_ready), .cs(cs), .hit_idx(hit_idx),
        .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       berr;
        logic [7:0] cs;
        logic [4:0] idx;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   edges = 0, start_edge = 0;
    logic prev_dtack = 1'b1, prev_berr = 1'b1;
    logic [7:0] cs_seen = '0;

    always @(posedge clk_sys) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // monitor: invariants every cycle, scoreboard pop on each DTACK or BERR falling
    always @(negedge clk_sys) begin
        exp_t e;
        if (reset_n) begin
            check("onehot", 32'($countones(cs) <= 1), 32'd1);
            if (cs != '0) check("idx_vs_cs", 32'(cs), 32'(8'd1 << hit_idx));
            if (busy && cs_seen != '0) check("cs_stable", 32'(cs), 32'(cs_seen));
            cs_seen = !busy ? '0 : (cs_seen != '0 ? cs_seen : cs);
            check("dtack_with_berr", 32'(!cpu_dtack_n && !cpu_berr_n), 32'd0);
            if ((prev_dtack && !cpu_dtack_n) || (prev_berr && !cpu_berr_n)) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("resp_kind_berr", 32'(!cpu_berr_n), 32'(e.berr));
                    check("resp_cs", 32'(cs), 32'(e.cs));
                    check("resp_idx", 32'(hit_idx), 32'(e.idx));
                    check("resp_latency", 32'(edges - start_edge + 1), 32'(e.lat));
                end
            end
        end
        prev_dtack = cpu_dtack_n;
        prev_berr  = cpu_berr_n;
    end

    task automatic start(input logic [23:0] a, input logic expect_resp, input logic eb,
                         input logic [7:0] ecs, input logic [4:0] eidx, input int lat);
        @(negedge clk_sys);
        cpu_a = a;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        start_edge = edges + 1;
        if (expect_resp) sb.push_back('{eb, ecs, eidx, lat});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic release_bus();
        @(negedge clk_sys);
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        @(negedge clk_sys);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cs", 32'(cs), 32'd0);
        check("idle_idx", 32'(hit_idx), 32'd0);
        check("idle_dtack", 32'(cpu_dtack_n), 32'd1);
        check("idle_berr", 32'(cpu_berr_n), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"}, 32'(cs), 32'd0);
        check({tag, "_idx"}, 32'(hit_idx), 32'd0);
        check({tag, "_dtack"}, 32'(cpu_dtack_n), 32'd1);
        check({tag, "_berr"}, 32'(cpu_berr_n), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_sys);
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // strobes with no data strobe must not start a cycle
        cpu_as_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("no_ds_busy", 32'(busy), 32'd0);
        cpu_as_n = 1'b1;
        @(negedge clk_sys);

        // region 0, no wait: DTACK on 3rd edge
        start(24'h001234, 1'b1, 1'b0, 8'h01, 5'd0, 3);
        drain(20);
        release_bus();

        // region 3, five waits
        start(24'h140002, 1'b1, 1'b0, 8'h08, 5'd3, 8);
        drain(30);
        release_bus();

        // region 2 alone, three waits
        start(24'h118000, 1'b1, 1'b0, 8'h04, 5'd2, 6);
        drain(30);
        release_bus();

        // region 5, maximum wait of 15
        start(24'h180000, 1'b1, 1'b0, 8'h20, 5'd5, 18);
        drain(40);
        release_bus();

        // overlap of regions 1 and 2: region 1 wins; address moves mid-cycle without re-decode
        start(24'h100010, 1'b1, 1'b0, 8'h02, 5'd1, 4);
        repeat (2) @(negedge clk_sys);
        cpu_a = 24'h140000;
        drain(30);
        release_bus();

        // ext_ready region: early pulse at cnt=1 ignored, later rise ends the wait
        start(24'h200000, 1'b1, 1'b0, 8'h10, 5'd4, 15);
        repeat (3) @(negedge clk_sys);
        ext_ready = 1'b1;
        @(negedge clk_sys);
        ext_ready = 1'b0;
        repeat (10) @(negedge clk_sys);
        ext_ready = 1'b1;
        drain(30);
        ext_ready = 1'b0;
        release_bus();

        // unmapped address
`ifdef BERR_TIMEOUT_EN
        start(24'h300000, 1'b1, 1'b1, 8'h00, 5'd0, 18);
        drain(40);
`else
        start(24'h300000, 1'b0, 1'b0, 8'h00, 5'd0, 0);
        repeat (30) @(negedge clk_sys);
        check("unmap_dtack", 32'(cpu_dtack_n), 32'd1);
        check("unmap_berr", 32'(cpu_berr_n), 32'd1);
        check("unmap_cs", 32'(cs), 32'd0);
        check("unmap_busy", 32'(busy), 32'd1);
`endif
        release_bus();

        // abort in WAIT, then async reset while in ACK
        start(24'h140002, 1'b0, 1'b0, 8'h00, 5'd0, 0);
        repeat (3) @(negedge clk_sys);
        check("abort_pre_busy", 32'(busy), 32'd1);
        release_bus();
        start(24'h000100, 1'b1, 1'b0, 8'h01, 5'd0, 3);
        drain(20);
        @(negedge clk_sys);
        check("ack_dtack_low", 32'(cpu_dtack_n), 32'd0);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_reset");
        cpu_as_n = 1'b1;
        cpu_ds_n = 2'b11;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        start(24'h07FFFF, 1'b1, 1'b0, 8'h01, 5'd0, 3);
        drain(20);
        release_bus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
